// File: rtl/shiftrows_sched.sv
// shiftrows_sched: byte-serial AES ShiftRows scheduler; define SHIFTROWS_SCHED_GAP_ERR_EN for a sticky err_gap
module shiftrows_sched #(
    parameter int          LAT   = 12,
    parameter logic [31:0] SCHED = 32'h1B1B1B1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] perm_din,
    output logic [1:0] perm_c3,
    input  logic [7:0] perm_dout,
    output logic       out_valid,
    output logic       out_first,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       err_gap
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam logic [3:0] LOFF = 4'(LAT);
    state_t         state, state_nx;
    logic [3:0]     slot, slot_nx, tap;
    logic [LAT-1:0] v_pipe, f_pipe;
    logic           acc, start;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot  <= 4'd0;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
        end
    end
    // a new block may only begin at slot 0 of IDLE or FLUSH; RUN slot 0 decides run-on vs drain
    always_comb begin
        start    = state == IDLE || (state == FLUSH && slot == 4'd0);
        state_nx = start ? (in_valid ? RUN : IDLE)
                 : (state == RUN && slot == 4'd0 && !in_valid) ? FLUSH
                 : state == FLUSH ? FLUSH
                 : state == RUN ? RUN : IDLE;
        slot_nx  = state_nx == IDLE ? 4'd0 : slot + 4'd1;
    end
    always_comb begin
        in_ready = state != FLUSH || slot == 4'd0;
        acc      = in_valid && in_ready;
        perm_din = acc ? in_data : 8'h00;
        tap      = slot - LOFF;
        perm_c3  = state == IDLE ? 2'b00 : SCHED[{tap, 1'b0} +: 2];
        busy     = state != IDLE;
        out_data = perm_dout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            f_pipe <= '0;
        end else begin
            v_pipe <= (v_pipe << 1) | LAT'(acc);
            f_pipe <= (f_pipe << 1) | LAT'(acc && slot == 4'd0);
        end
    end
    assign out_valid = v_pipe[LAT-1];
    assign out_first = f_pipe[LAT-1];
`ifdef SHIFTROWS_SCHED_GAP_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) err_gap <= 1'b0;
        else if (state == RUN && slot != 4'd0 && !in_valid) err_gap <= 1'b1;
    end
`else
    assign err_gap = 1'b0;
`endif
endmodule
